// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder exposing a byte-wide register file over 16-bit command frames.
// All SPI pins are oversampled in the mclk_i_clk domain; no logic runs on SCLK itself.
module spi_slave_regs #(
    parameter int          NUM_REGS  = 8,
    parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
    input  logic                  mclk_i_clk,
    input  logic                  mclk_reset_reset_n,
    input  logic                  spi_sclk_i,
    input  logic                  spi_ss_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_strobe_o,
    output logic [6:0]            wr_addr_o
);

    // state    | meaning
    // ST_IDLE  | waiting for an armed SS_n falling edge
    // ST_CMD   | shifting in R/W + address (bits 15..8)
    // ST_DATA  | shifting rx data in, tx data out (bits 7..0)
    // ST_DONE  | frame complete, extra SCLK edges ignored
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;

    // bit0 = first sync stage, bit1 = synchronized value, bit2 = history
    logic [2:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [NUM_REGS-1:0][7:0] regs_q, regs_d;

    logic sclk_rise, sclk_fall, ss_high, ss_fall, mosi_s;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_high   = ss_sync_q[1];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];

    function automatic logic [7:0] read_data(input logic [6:0] addr);
        logic [7:0] val;
        val = 8'h00;
        if (addr == 7'h7F) val = DEVICE_ID;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) val = regs_q[i];
        end
        return val;
    endfunction

    // SS_n may already be low when reset releases; only arm once the synchronizer
    // holds a genuine post-reset sample of SS_n high, so a frame in flight is skipped.
    always_comb begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd2) & ss_high);
    end

    always_comb begin
        logic hit;
        hit         = 1'b0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        if (ss_high) begin
            bit_cnt_d = 5'd0;
        end else if (sclk_rise && bit_cnt_q < 5'd16) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (armed_q && ss_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                miso_d = 1'b0;
                if (sclk_rise) begin
                    cmd_d = {cmd_q[6:0], mosi_s};
                    if (bit_cnt_q == 5'd7) begin
                        state_d = ST_DATA;
                        tx_d    = read_data(cmd_d[6:0]);
                    end
                end
            end
            ST_DATA: begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_d = {rx_q[6:0], mosi_s};
                    if (bit_cnt_q == 5'd15) begin
                        state_d = ST_DONE;
                        miso_d  = 1'b0;
                        if (!cmd_q[7]) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (cmd_q[6:0] == 7'(i)) begin
                                    regs_d[i] = rx_d;
                                    hit       = 1'b1;
                                end
                            end
                        end
                        if (hit) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = cmd_q[6:0];
                        end
                    end
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase

        if (ss_high) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end
    end

    always_ff @(posedge mclk_i_clk or negedge mclk_reset_reset_n) begin
        if (!mclk_reset_reset_n) begin
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 3'b000;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            cmd_q       <= 8'h00;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk_i};
            ss_sync_q   <= {ss_sync_q[1:0], spi_ss_n_i};
            mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi_i};
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign spi_miso_oe = ~ss_sync_q[1];
    assign regs_o      = regs_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;

endmodule
